instr_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle/mini-MIPS datapath: owns the program counter, drives the word-addressed instruction memory's `pc` input, and captures the returned word into a registered fetch output with a valid/ready handshake toward decode. It sits in front of decode. It accepts control-flow redirects from execute and optionally resolves unconditional jumps locally. Instruction memory is asynchronous-read: the word for `imem_pc` is available in the same cycle.

---
 rtl/instr_fetch_unit_pkg.sv | 11 +
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/ifu_predecode.sv | 17 +
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Consumers import ifu_pkg::*.
package ifu_pkg;

  typedef logic [31:0] addr_t;

  localparam int        WORD_BYTES       = 4;
  localparam logic [5:0] OPC_JUMP        = 6'h04;
  localparam addr_t     DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem port, execute redirect and decode handshake.
// master = fetch unit, slave = surrounding pipeline / memory.
interface instr_fetch_unit_if;
  import ifu_pkg::*;

  addr_t       imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  addr_t       redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  addr_t       if_pc;
  addr_t       if_pc_plus4;
  logic        misalign_err;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_target,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output misalign_err
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_target,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  misalign_err
  );

endinterface

// File: rtl/ifu_predecode.sv
// Combinational predecode of the unconditional jump form
// (opcode OPC_JUMP with rs == rt == 0) and its word-scaled target.
module ifu_predecode
  import ifu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_jump,
  output addr_t       jump_target
);

  assign is_jump = (instr[31:26] == OPC_JUMP)
                && (instr[25:21] == 5'd0)
                && (instr[20:16] == 5'd0);

  assign jump_target = {14'b0, instr[15:0], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, async-read imem port, registered output to decode.
// Define IFU_EARLY_JUMP_EN to resolve unconditional jumps in fetch.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);

  addr_t       pc;
  addr_t       pc_plus4;
  addr_t       next_pc;
  logic        advance;
  logic        out_valid;
  logic [31:0] out_instr;
  addr_t       out_pc;
  addr_t       out_pc_plus4;
  logic        misalign;

  assign pc_plus4 = pc + addr_t'(WORD_BYTES);
  assign advance  = !out_valid || bus.if_ready;

`ifdef IFU_EARLY_JUMP_EN
  logic  is_jump;
  addr_t jump_target;

  ifu_predecode u_predecode (
    .instr       (bus.imem_instr),
    .is_jump     (is_jump),
    .jump_target (jump_target)
  );

  assign next_pc = is_jump ? jump_target : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  // Program counter: redirect beats sequential/jump advance, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_target[31:2], 2'b00};
    end else if (advance) begin
      pc <= next_pc;
    end
  end

  // Output register: flush on redirect, load on advance, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= addr_t'(WORD_BYTES);
    end else if (bus.redirect_valid) begin
      out_valid    <= 1'b0;
    end else if (advance) begin
      out_valid    <= 1'b1;
      out_instr    <= bus.imem_instr;
      out_pc       <= pc;
      out_pc_plus4 <= pc_plus4;
    end
  end

  // Misalignment flag lives exactly one cycle after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= bus.redirect_valid && (|bus.redirect_target[1:0]);
    end
  end

  assign bus.imem_pc      = pc;
  assign bus.if_valid     = out_valid;
  assign bus.if_instr     = out_instr;
  assign bus.if_pc        = out_pc;
  assign bus.if_pc_plus4  = out_pc_plus4;
  assign bus.misalign_err = misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a scoreboard of
// expected fetch-register contents and directed scenario checks.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];

  always_comb bus.imem_instr = mem[bus.imem_pc[7:2]];

  exp_t        exp_q [$];
  logic [31:0] m_pc;
  logic        m_mis;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[7:2]];
`ifdef IFU_EARLY_JUMP_EN
    if (w[31:26] == 6'h04 && w[25:16] == 10'd0)
      return {14'b0, w[15:0], 2'b00};
`endif
    return pc + 32'd4;
  endfunction

  // One clock cycle with given inputs; scoreboard push/pop and checks.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] tgt);
    exp_t e;
    bus.if_ready        = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    #1;
    if (bus.if_valid && rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.if_pc !== e.pc || bus.if_instr !== e.instr ||
          bus.if_pc_plus4 !== e.pc + 32'd4) begin
        n_bad++;
        $display("FAIL handshake: pc=%h instr=%h p4=%h want pc=%h instr=%h p4=%h",
                 bus.if_pc, bus.if_instr, bus.if_pc_plus4,
                 e.pc, e.instr, e.pc + 32'd4);
      end
    end
    if (rv) begin
      exp_q.delete();
      m_pc  = {tgt[31:2], 2'b00};
      m_mis = |tgt[1:0];
    end else begin
      m_mis = 1'b0;
      if (exp_q.size() == 0 || rdy) begin
        exp_q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]]});
        m_pc = model_next(m_pc);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.imem_pc !== m_pc || bus.misalign_err !== m_mis ||
        bus.if_valid !== (exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL state: imem_pc=%h mis=%b valid=%b want %h %b %b",
               bus.imem_pc, bus.misalign_err, bus.if_valid,
               m_pc, m_mis, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (bus.if_pc !== exp_q[0].pc || bus.if_instr !== exp_q[0].instr) begin
        n_bad++;
        $display("FAIL outreg: pc=%h instr=%h want %h %h",
                 bus.if_pc, bus.if_instr, exp_q[0].pc, exp_q[0].instr);
      end
    end
  endtask

  // Release reset and wait (bounded) for the first fetched word.
  task automatic release_and_sync();
    bit got;
    got = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.if_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got || bus.if_pc !== 32'h0 || bus.if_instr !== mem[0]) begin
      n_bad++;
      $display("FAIL first_fetch: valid=%b pc=%h instr=%h want 1 0 %h",
               bus.if_valid, bus.if_pc, bus.if_instr, mem[0]);
    end
    exp_q.delete();
    exp_q.push_back('{pc: 32'h0, instr: mem[0]});
    m_pc  = model_next(32'h0);
    m_mis = 1'b0;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bus.if_ready        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    #12;
    n_cmp++;
    if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 ||
        bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h4 ||
        bus.misalign_err !== 1'b0 || bus.imem_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: valid=%b instr=%h pc=%h p4=%h mis=%b ipc=%h",
               bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus4,
               bus.misalign_err, bus.imem_pc);
    end
    release_and_sync();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.if_pc !== 32'(k * 4) || bus.if_instr !== mem[k]) begin
        n_bad++;
        $display("FAIL seq%0d: pc=%h instr=%h want %h %h",
                 k, bus.if_pc, bus.if_instr, 32'(k * 4), mem[k]);
      end
      if (k < 2) cyc(1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, '0);
      n_cmp++;
      if (bus.if_pc !== 32'd8 || bus.if_instr !== mem[2] ||
          bus.imem_pc !== 32'd12 || bus.if_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL stall%0d: pc=%h instr=%h ipc=%h valid=%b want 8 %h c 1",
                 k, bus.if_pc, bus.if_instr, bus.imem_pc, bus.if_valid, mem[2]);
      end
    end
    cyc(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.if_pc !== 32'd12) begin
      n_bad++;
      $display("FAIL stall_release: pc=%h want 0000000c", bus.if_pc);
    end
  endtask

  task automatic test_early_jump();
    logic [31:0] after_jump;
`ifdef IFU_EARLY_JUMP_EN
    after_jump = 32'd112;
`else
    after_jump = 32'd24;
`endif
    cyc(1'b1, 1'b1, 32'd16);
    n_cmp++;
    if (bus.if_valid !== 1'b0 || bus.imem_pc !== 32'd16) begin
      n_bad++;
      $display("FAIL jump_redirect: valid=%b ipc=%h want 0 10",
               bus.if_valid, bus.imem_pc);
    end
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.if_pc !== 32'd20 || bus.if_instr !== 32'h1000_001C) begin
      n_bad++;
      $display("FAIL jump_word: pc=%h instr=%h want 14 1000001c",
               bus.if_pc, bus.if_instr);
    end
    cyc(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.if_pc !== after_jump || bus.if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL jump_next: pc=%h valid=%b want %h 1",
               bus.if_pc, bus.if_valid, after_jump);
    end
  endtask

  task automatic test_redirect_stalled();
    cyc(1'b0, 1'b1, 32'h70);
    n_cmp++;
    if (bus.if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush: valid=%b want 0", bus.if_valid);
    end
    cyc(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.if_pc !== 32'h70 || bus.if_instr !== mem[28] ||
        bus.if_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redirect_target: pc=%h instr=%h valid=%b want 70 %h 1",
               bus.if_pc, bus.if_instr, bus.if_valid, mem[28]);
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b1, 1'b1, 32'h73);
    n_cmp++;
    if (bus.imem_pc !== 32'h70 || bus.misalign_err !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_set: ipc=%h mis=%b want 70 1",
               bus.imem_pc, bus.misalign_err);
    end
    cyc(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.misalign_err !== 1'b0 || bus.if_pc !== 32'h70) begin
      n_bad++;
      $display("FAIL misalign_pulse: mis=%b pc=%h want 0 70",
               bus.misalign_err, bus.if_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    for (int i = 0; i < 60; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 255));
      cyc(rdy, rv, rv ? tgt : 32'h0);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h0 ||
        bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h4 ||
        bus.if_instr !== 32'h0 || bus.misalign_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b ipc=%h pc=%h p4=%h instr=%h mis=%b",
               bus.if_valid, bus.imem_pc, bus.if_pc, bus.if_pc_plus4,
               bus.if_instr, bus.misalign_err);
    end
    release_and_sync();
    cyc(1'b1, 1'b0, '0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_pc  = '0;
    m_mis = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i);
    mem[5] = 32'h1000_001C;
    test_reset();
    test_sequential();
    test_backpressure();
    test_early_jump();
    test_redirect_stalled();
    test_misaligned();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
